led_pulse_stretch: RTL

Output-side counterpart to the switch debounce path. It takes WIDTH independent, synchronous event lines, typically single-cycle strobes from game logic, and drives LED outputs. Every event stays visible for a guaranteed minimum hold time of 2^(N-1) clocks. It sits between core logic and the board LED pins, in the same clock domain as the debounced switch bank.

---
 rtl/led_pkg.sv | 14 +
 rtl/pulse_stretch_ch.sv | 64 ++++++
 rtl/led_pulse_stretch.sv | 29 ++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED pulse-stretch path.
// Channel state encoding and default geometry.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_HOLD = 2'b10
    } ch_state_t;

    localparam int DEF_WIDTH = 18;
    localparam int DEF_N     = 11;

endpackage

// File: rtl/pulse_stretch_ch.sv
// One LED channel: IDLE/ON/HOLD FSM with hold counter.
// Output is a register fed from next state, so no path from ev.
module pulse_stretch_ch
    import led_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic clk,
    input  logic n_reset,
    input  logic ev,
    output logic led
);

    localparam logic [N-1:0] LAST = {1'b0, {(N-1){1'b1}}};

    ch_state_t      state, state_n;
    logic [N-1:0]   count, count_n;
    logic           led_n;

    always_comb begin
        state_n = state;
        count_n = count;
        case (state)
            ST_IDLE: begin
                count_n = '0;
                if (ev) state_n = ST_ON;
            end
            ST_ON: begin
                count_n = '0;
                if (!ev) state_n = ST_HOLD;
            end
            ST_HOLD: begin
                // retrigger wins over terminal count
                if (ev) begin
                    state_n = ST_ON;
                    count_n = '0;
                end else if (count == LAST) begin
                    state_n = ST_IDLE;
                    count_n = '0;
                end else begin
                    count_n = count + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                count_n = '0;
            end
        endcase
        led_n = (state_n == ST_ON) || (state_n == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= ST_IDLE;
            count <= '0;
            led   <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            led   <= led_n;
        end
    end

endmodule

// File: rtl/led_pulse_stretch.sv
// Bank of independent LED pulse stretchers.
// Each event stays visible for at least 2^(N-1) clocks.
module led_pulse_stretch
    import led_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] ev_in,
    output logic [WIDTH-1:0] led_out,
    output logic             any_active
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pulse_stretch_ch #(
            .N(N)
        ) u_ch (
            .clk     (clk),
            .n_reset (n_reset),
            .ev      (ev_in[i]),
            .led     (led_out[i])
        );
    end

    assign any_active = |led_out;

endmodule
